sopc_uart_tx: RTL and testbench

Memory-mapped UART transmitter that hangs off the CPU data-memory port of the minimal SOPC, alongside `data_ram`. The top-level decodes its address window and routes `ce`/`we`/`sel`/`addr`/`data` to it. It buffers bytes written by the CPU in a FIFO and serialises them as 8N1 frames on `txd`. Its interrupt output feeds a spare bit of the CPU `int_i` vector.

---
 rtl/sopc_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_sopc_uart_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sopc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, status/control registers and a level IRQ.
// state | meaning: IDLE line high, wait for FIFO data | START start bit | DATA 8 data bits LSB first | STOP stop bit
module sopc_uart_tx #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BIT_LAST = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d, irq_en_q, irq_en_d;
    logic            txd_q, txd_d, irq_q, irq_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic wr_en, push_req, ctrl_wr, full, empty, push, pop;
    logic unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:8]};

    always_comb begin
        wr_en    = ce & we & (sel != 4'b0);
        push_req = wr_en & (addr[3:2] == 2'd0);
        ctrl_wr  = wr_en & (addr[3:2] == 2'd2);
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        push     = push_req & ~full;
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = BIT_LAST;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    timer_d   = BIT_LAST;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = BIT_LAST;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                if (timer_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
        endcase
    end

    // A push into a full FIFO is dropped even when a pop frees a slot on the same edge.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
        if (ctrl_wr) begin
            irq_en_d = data_i[0];
            if (data_i[1]) begin
                ovf_d = 1'b0;
            end
        end
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = irq_en_d & (count_d == '0) & (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (ce) begin
            case (addr[3:2])
                2'd1:    data_o = {16'd0, 8'(count_q), 4'd0, ovf_q, (state_q != S_IDLE), empty, full};
                2'd2:    data_o = {31'd0, irq_en_q};
                default: data_o = 32'd0;
            endcase
        end
    end

    assign txd   = txd_q;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_sopc_uart_tx.sv
// Bench for sopc_uart_tx: queue/time-based reference model checked every cycle, plus directed literal checks.
module tb_sopc_uart_tx;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, ce, we;
    logic [3:0]  sel;
    logic [31:0] addr, data_i, data_o;
    logic        txd, irq_o;

    int vectors = 0;
    int miscompares = 0;

    initial forever #5 clk = ~clk;

    sopc_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ce(ce), .we(we), .sel(sel), .addr(addr),
        .data_i(data_i), .data_o(data_o), .txd(txd), .irq_o(irq_o)
    );

    // Reference model: FIFO as a queue, frame as "edges since start" arithmetic.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] m_cur;
    logic       m_active = 1'b0, m_ovf = 1'b0, m_irq_en = 1'b0;
    logic       m_irq, m_txd, m_push, m_full, mvalid = 1'b0;
    int         m_t = 0, m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(mq.size()), 4'h0, m_ovf, m_active, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
            m_irq_en = 1'b0;
            m_t      = 0;
            mvalid   = 1'b1;
        end else if (mvalid) begin
            m_full = (mq.size() == DEPTH);
            m_push = ce && we && (sel != 4'h0) && (addr[3:2] == 2'd0);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * DIV) m_active = 1'b0;
            end else if (mq.size() > 0) begin
                m_cur = mq.pop_front();
                sent.push_back(m_cur);
                m_active = 1'b1;
                m_t = 0;
            end
            if (m_push) begin
                if (m_full) m_ovf = 1'b1;
                else mq.push_back(data_i[7:0]);
            end
            if (ce && we && (sel != 4'h0) && (addr[3:2] == 2'd2)) begin
                m_irq_en = data_i[0];
                if (data_i[1]) m_ovf = 1'b0;
            end
        end
        m_irq = m_irq_en && (mq.size() == 0) && !m_active;
        m_txd = 1'b1;
        if (m_active) begin
            m_b = m_t / DIV;
            if (m_b == 0) m_txd = 1'b0;
            else if (m_b <= 8) m_txd = m_cur[m_b-1];
        end
        #1;
        if (mvalid) begin
            check("cyc_txd", {31'd0, txd}, {31'd0, m_txd});
            check("cyc_irq", {31'd0, irq_o}, {31'd0, m_irq});
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; sel = s; addr = a; data_i = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = a;
        #1;
        check(name, data_o, exp);
        ce = 1'b0; sel = 4'h0;
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        ce = 1'b1; we = 1'b0; sel = 4'h0; addr = 32'h4;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (data_o == 32'h2) done = 1'b1;
        end
        ce = 1'b0;
        check("idle_wait", {31'd0, done}, 32'd1);
    endtask

    logic bits_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] want;
    int lows;

    initial begin
        reset = 1'b1; ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; data_i = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        rd_chk(32'h4, 32'h0000_0002, "rst_status");
        rd_chk(32'h8, 32'h0000_0000, "rst_ctrl");

        // Single frame of 0xA5: start j=1..4, data j=5..36, stop from 37, idle at 41.
        wr(32'h0, 32'hA5, 4'h1);
        ce = 1'b1; we = 1'b0; sel = 4'h0; addr = 32'h4;
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            #1;
            if (j <= 4) want = 32'd0;
            else if (j <= 36) want = {31'd0, bits_a5[(j-5)/4]};
            else want = 32'd1;
            check($sformatf("a5_txd_c%0d", j), {31'd0, txd}, want);
            if (j == 40) check("a5_busy_c40", data_o & 32'h4, 32'h4);
            if (j == 41) check("a5_status_c41", data_o, 32'h2);
        end
        ce = 1'b0;

        // Overflow: six back-to-back writes into a depth-4 FIFO.
        sent.delete();
        for (int i = 0; i < 6; i++) wr(32'h0, 32'h11 * (i + 1), 4'hF);
        rd_chk(32'h4, 32'h0000_040D, "ovf_status");
        wr(32'h8, 32'h2, 4'hF);
        rd_chk(32'h4, 32'h0000_0405, "ovf_cleared");
        wait_idle(400);
        check("ovf_frames", sent.size(), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("ovf_order%0d", i), {24'd0, sent[i]}, 32'h11 * (i + 1));

        // Interrupt.
        wr(32'h8, 32'h1, 4'hF);
        check("irq_set", {31'd0, irq_o}, 32'd1);
        wr(32'h0, 32'h3C, 4'hF);
        check("irq_push", {31'd0, irq_o}, 32'd0);
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            if (j == 40) check("irq_c40", {31'd0, irq_o}, 32'd0);
            if (j == 41) check("irq_c41", {31'd0, irq_o}, 32'd1);
        end

        // Reset during data bit 3 (cycles 17..20) of 0x96, with 0x69 queued behind it.
        wr(32'h0, 32'h96, 4'hF);
        wr(32'h0, 32'h69, 4'hF);
        for (int j = 2; j <= 18; j++) @(negedge clk);
        check("mid_bit3", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        rd_chk(32'h4, 32'h0000_0002, "mid_rst_status");
        rd_chk(32'h8, 32'h0000_0000, "mid_rst_ctrl");
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("mid_quiet", lows, 32'd0);

        // Byte-lane and address decode.
        wr(32'h0, 32'h5A, 4'h0);
        repeat (3) @(negedge clk);
        rd_chk(32'h4, 32'h0000_0002, "sel0_status");
        check("sel0_txd", {31'd0, txd}, 32'd1);
        wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        rd_chk(32'h8, 32'h0000_0000, "addr3_ctrl");
        rd_chk(32'h4, 32'h0000_0002, "addr3_status");
        rd_chk(32'hC, 32'h0000_0000, "addr3_rd");
        wr(32'h8, 32'h3, 4'hF);
        rd_chk(32'h8, 32'h0000_0001, "ctrl_rd");
        rd_chk(32'h0, 32'h0000_0000, "txdata_rd");
        rd_chk(32'h4, m_status(), "status_model");
        ce = 1'b0; we = 1'b0; addr = 32'h8;
        #1;
        check("ce0_rd", data_o, 32'h0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
